// File: rtl/vga_timing_gen_if.sv
// vga_timing_gen_if
// Bundles the pattern-select input and all raster/pixel outputs of the VGA
// timing generator. Port names follow the board-level pin names.
//   SW           2 bits      pattern mode select (into the generator)
//   VGA_HS_O     1 bit       horizontal sync
//   VGA_VS_O     1 bit       vertical sync
//   VGA_R/G/B    COLOR_BITS  colour channels
//   pix_x        X_W bits    x of the pixel currently on the outputs
//   pix_y        Y_W bits    y of the pixel currently on the outputs
//   active       1 bit       output pixel is inside the visible area
//   frame_start  1 bit       one-cycle pulse when pixel (0,0) is presented
// master: the generator side; slave: the consumer / pattern-select side.
interface vga_timing_gen_if #(
    parameter int COLOR_BITS = 4,
    parameter int X_W        = 10,
    parameter int Y_W        = 10
);
    logic [1:0]            SW;
    logic                  VGA_HS_O;
    logic                  VGA_VS_O;
    logic [COLOR_BITS-1:0] VGA_R;
    logic [COLOR_BITS-1:0] VGA_G;
    logic [COLOR_BITS-1:0] VGA_B;
    logic [X_W-1:0]        pix_x;
    logic [Y_W-1:0]        pix_y;
    logic                  active;
    logic                  frame_start;

    modport master (
        input  SW,
        output VGA_HS_O, VGA_VS_O, VGA_R, VGA_G, VGA_B,
        output pix_x, pix_y, active, frame_start
    );

    modport slave (
        output SW,
        input  VGA_HS_O, VGA_VS_O, VGA_R, VGA_G, VGA_B,
        input  pix_x, pix_y, active, frame_start
    );
endinterface

// File: rtl/vga_timing_gen.sv
// vga_timing_gen
// Parametrised VGA raster generator with a four-pattern test-pattern engine.
// A clock divider produces a pixel clock-enable from CLK_I; horizontal and
// vertical counters advance on that enable, and every output is registered
// from the current counter position, so pins lag the counters by one pixel.
// Ports:
//   CLK_I  system clock
//   reset  synchronous, active-high reset
//   bus    vga_timing_gen_if.master: SW in; sync, RGB, pix_x/pix_y,
//          active and frame_start out
module vga_timing_gen #(
    parameter int H_ACTIVE   = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_ACTIVE   = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33,
    parameter int HS_POL     = 0,
    parameter int VS_POL     = 0,
    parameter int CLK_DIV    = 4,
    parameter int COLOR_BITS = 4,
    parameter int CHK_LOG2   = 5,
    parameter int RAMP_SHIFT = 3
) (
    input logic             CLK_I,
    input logic             reset,
    vga_timing_gen_if.master bus
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);
    localparam int DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BAR_W   = H_ACTIVE / 8;
    localparam int BW      = (BAR_W > 1) ? $clog2(BAR_W) : 1;

    localparam logic [DW-1:0]         DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [HW-1:0]         H_LAST   = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0]         V_LAST   = VW'(V_TOTAL - 1);
    localparam logic [HW-1:0]         H_VIS    = HW'(H_ACTIVE);
    localparam logic [VW-1:0]         V_VIS    = VW'(V_ACTIVE);
    localparam logic [HW-1:0]         HS_START = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0]         HS_END   = HW'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [VW-1:0]         VS_START = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0]         VS_END   = VW'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic [BW-1:0]         BAR_LAST = BW'(BAR_W - 1);
    localparam logic                  HS_ON    = (HS_POL != 0);
    localparam logic                  VS_ON    = (VS_POL != 0);
    localparam logic [COLOR_BITS-1:0] MAX      = '1;

    logic [DW-1:0]         div_cnt;
    logic                  pix_ce;
    logic [HW-1:0]         h;
    logic [VW-1:0]         v;
    logic [BW-1:0]         bar_pos;
    logic [2:0]            bar_idx;
    logic [1:0]            mode_q;
    logic                  at_origin;
    logic [1:0]            eff_mode;

    logic                  hs_n, vs_n, act_n;
    logic [COLOR_BITS-1:0] r_n, g_n, b_n;

    logic                  hs_q, vs_q, act_q, fs_q;
    logic [COLOR_BITS-1:0] r_q, g_q, b_q;
    logic [HW-1:0]         x_q;
    logic [VW-1:0]         y_q;

    assign pix_ce    = (div_cnt == DIV_LAST);
    assign at_origin = (h == '0) && (v == '0);
    // The pixel at (0,0) already uses the freshly sampled SW, so the whole
    // new frame, including its first pixel, shows one pattern.
    assign eff_mode  = at_origin ? bus.SW : mode_q;

    // Pixel clock-enable divider; with CLK_DIV=1 it stays at 0 and fires
    // every cycle.
    always_ff @(posedge CLK_I) begin
        if (reset || pix_ce) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + DW'(1);
        end
    end

    // Raster counters plus a bar tracker that follows h so the colour-bar
    // index needs no divider; mode is latched only at the frame origin.
    always_ff @(posedge CLK_I) begin
        if (reset) begin
            h       <= '0;
            v       <= '0;
            bar_pos <= '0;
            bar_idx <= '0;
            mode_q  <= '0;
        end else if (pix_ce) begin
            if (at_origin) begin
                mode_q <= bus.SW;
            end
            if (h == H_LAST) begin
                h       <= '0;
                bar_pos <= '0;
                bar_idx <= '0;
                v       <= (v == V_LAST) ? '0 : v + VW'(1);
            end else begin
                h <= h + HW'(1);
                if (bar_pos == BAR_LAST) begin
                    bar_pos <= '0;
                    if (bar_idx != 3'd7) begin
                        bar_idx <= bar_idx + 3'd1;
                    end
                end else begin
                    bar_pos <= bar_pos + BW'(1);
                end
            end
        end
    end

    // Next output values derived from the current counter position.
    always_comb begin
        hs_n  = ((h >= HS_START) && (h <= HS_END)) ? HS_ON : ~HS_ON;
        vs_n  = ((v >= VS_START) && (v <= VS_END)) ? VS_ON : ~VS_ON;
        act_n = (h < H_VIS) && (v < V_VIS);
        r_n   = '0;
        g_n   = '0;
        b_n   = '0;
        case (eff_mode)
            2'd0: begin
                r_n = MAX;
                g_n = MAX;
                b_n = MAX;
            end
            2'd1: begin
                r_n = bar_idx[2] ? MAX : '0;
                g_n = bar_idx[1] ? MAX : '0;
                b_n = bar_idx[0] ? MAX : '0;
            end
            2'd2: begin
                r_n = (h[CHK_LOG2] ^ v[CHK_LOG2]) ? MAX : '0;
                g_n = r_n;
                b_n = r_n;
            end
            default: begin
                r_n = COLOR_BITS'(h >> RAMP_SHIFT);
                g_n = r_n;
                b_n = r_n;
            end
        endcase
        if (!act_n) begin
            r_n = '0;
            g_n = '0;
            b_n = '0;
        end
    end

    // Output register: loads once per pixel tick and holds in between;
    // frame_start is rebuilt every cycle so it lasts exactly one CLK_I.
    always_ff @(posedge CLK_I) begin
        if (reset) begin
            hs_q  <= ~HS_ON;
            vs_q  <= ~VS_ON;
            r_q   <= '0;
            g_q   <= '0;
            b_q   <= '0;
            x_q   <= '0;
            y_q   <= '0;
            act_q <= 1'b0;
            fs_q  <= 1'b0;
        end else begin
            fs_q <= pix_ce && at_origin;
            if (pix_ce) begin
                hs_q  <= hs_n;
                vs_q  <= vs_n;
                r_q   <= r_n;
                g_q   <= g_n;
                b_q   <= b_n;
                x_q   <= h;
                y_q   <= v;
                act_q <= act_n;
            end
        end
    end

    assign bus.VGA_HS_O    = hs_q;
    assign bus.VGA_VS_O    = vs_q;
    assign bus.VGA_R       = r_q;
    assign bus.VGA_G       = g_q;
    assign bus.VGA_B       = b_q;
    assign bus.pix_x       = x_q;
    assign bus.pix_y       = y_q;
    assign bus.active      = act_q;
    assign bus.frame_start = fs_q;
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen
// Drives two generator builds of a small 14x7 raster from one clock and one
// SW/reset source: dut_a with CLK_DIV=2 and active-low HS, dut_b with
// CLK_DIV=1 and active-high HS. Each cycle both are compared against a
// reference model that derives the presented pixel from the number of clock
// edges since reset, plus frame-period checks on frame_start.
// Ports: none (top-level bench).
module tb_vga_timing_gen;
    localparam int H_ACTIVE = 8;
    localparam int H_FP     = 2;
    localparam int H_SYNC   = 2;
    localparam int H_BP     = 2;
    localparam int V_ACTIVE = 4;
    localparam int V_FP     = 1;
    localparam int V_SYNC   = 1;
    localparam int V_BP     = 1;
    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int FRAME    = H_TOTAL * V_TOTAL;
    localparam int CHK      = 1;
    localparam int RSHIFT   = 0;

    logic       CLK_I = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] sw_cur = 2'd0;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int ka       = 0;
    int kb       = 0;
    int last_fa  = -1;
    int last_fb  = -1;
    logic [1:0]  mode_a = 2'd0;
    logic [1:0]  mode_b = 2'd0;
    logic [22:0] exp_a  = '0;
    logic [22:0] exp_b  = '0;

    always #5 CLK_I = ~CLK_I;

    vga_timing_gen_if #(.COLOR_BITS(4), .X_W(4), .Y_W(3)) bus_a ();
    vga_timing_gen_if #(.COLOR_BITS(4), .X_W(4), .Y_W(3)) bus_b ();

    vga_timing_gen #(
        .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
        .HS_POL(0), .VS_POL(0), .CLK_DIV(2), .COLOR_BITS(4),
        .CHK_LOG2(CHK), .RAMP_SHIFT(RSHIFT)
    ) dut_a (
        .CLK_I(CLK_I),
        .reset(reset),
        .bus(bus_a)
    );

    vga_timing_gen #(
        .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
        .HS_POL(1), .VS_POL(0), .CLK_DIV(1), .COLOR_BITS(4),
        .CHK_LOG2(CHK), .RAMP_SHIFT(RSHIFT)
    ) dut_b (
        .CLK_I(CLK_I),
        .reset(reset),
        .bus(bus_b)
    );

    // Reference: k edges after reset release give k/div pixel ticks; the
    // pixel on the pins is tick number k/div-1 laid out row by row.
    // Packing: {hs, vs, r, g, b, x[3:0], y[2:0], active, frame_start}.
    function automatic logic [22:0] modelOut(input int div, input logic hs_pol,
                                             input int k, input logic [1:0] mode);
        int p, x, y, bar;
        logic hs, vs, act, fs;
        logic [3:0] r, g, b;
        if (k < div) begin
            return {~hs_pol, 1'b1, 12'h000, 4'h0, 3'h0, 1'b0, 1'b0};
        end
        p   = k / div - 1;
        x   = p % H_TOTAL;
        y   = (p / H_TOTAL) % V_TOTAL;
        act = (x < H_ACTIVE) && (y < V_ACTIVE);
        hs  = (x >= H_ACTIVE + H_FP && x < H_ACTIVE + H_FP + H_SYNC) ? hs_pol : ~hs_pol;
        vs  = (y >= V_ACTIVE + V_FP && y < V_ACTIVE + V_FP + V_SYNC) ? 1'b0 : 1'b1;
        fs  = (k % div == 0) && (p % FRAME == 0);
        r = 4'h0;
        g = 4'h0;
        b = 4'h0;
        if (act) begin
            case (mode)
                2'd0: begin
                    r = 4'hF; g = 4'hF; b = 4'hF;
                end
                2'd1: begin
                    bar = x / (H_ACTIVE / 8);
                    if (bar > 7) bar = 7;
                    r = (bar >= 4) ? 4'hF : 4'h0;
                    g = (((bar / 2) % 2) == 1) ? 4'hF : 4'h0;
                    b = ((bar % 2) == 1) ? 4'hF : 4'h0;
                end
                2'd2: begin
                    r = (((x / (1 << CHK)) + (y / (1 << CHK))) % 2 == 1) ? 4'hF : 4'h0;
                    g = r; b = r;
                end
                default: begin
                    r = 4'((x / (1 << RSHIFT)) % 16);
                    g = r; b = r;
                end
            endcase
        end
        return {hs, vs, r, g, b, 4'(x), 3'(y), act, fs};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        if (obs === expv) begin
            n_pass++;
        end else begin
            $display("[TB] FAIL %s cycle %0d: got %0h, expected %0h", tag, cyc, obs, expv);
        end
    endtask

    // One clock: update the model with the SW/reset values seen at this
    // edge, compare both builds, then drive the next inputs.
    task automatic applyStimulus(input logic [1:0] sw_next, input logic rst_next);
        logic [22:0] obs;
        @(posedge CLK_I);
        #1;
        cyc++;
        if (reset) begin
            ka = 0; kb = 0; last_fa = -1; last_fb = -1;
        end else begin
            ka++; kb++;
            if (ka % 2 == 0 && ((ka / 2 - 1) % FRAME) == 0) mode_a = sw_cur;
            if (((kb - 1) % FRAME) == 0) mode_b = sw_cur;
        end
        exp_a = modelOut(2, 1'b0, ka, mode_a);
        exp_b = modelOut(1, 1'b1, kb, mode_b);
        obs = {bus_a.VGA_HS_O, bus_a.VGA_VS_O, bus_a.VGA_R, bus_a.VGA_G, bus_a.VGA_B,
               bus_a.pix_x, bus_a.pix_y, bus_a.active, bus_a.frame_start};
        checkOutput("dut_a_pins", 32'(obs), 32'(exp_a));
        obs = {bus_b.VGA_HS_O, bus_b.VGA_VS_O, bus_b.VGA_R, bus_b.VGA_G, bus_b.VGA_B,
               bus_b.pix_x, bus_b.pix_y, bus_b.active, bus_b.frame_start};
        checkOutput("dut_b_pins", 32'(obs), 32'(exp_b));
        if (bus_a.frame_start === 1'b1) begin
            if (last_fa >= 0) checkOutput("dut_a_period", 32'(cyc - last_fa), 32'(2 * FRAME));
            last_fa = cyc;
        end
        if (bus_b.frame_start === 1'b1) begin
            if (last_fb >= 0) checkOutput("dut_b_period", 32'(cyc - last_fb), 32'(FRAME));
            last_fb = cyc;
        end
        sw_cur    = sw_next;
        reset     = rst_next;
        bus_a.SW  = sw_next;
        bus_b.SW  = sw_next;
    endtask

    initial begin
        int guard;
        logic [1:0] sw_n;
        logic       rst_n;
        bus_a.SW = 2'd0;
        bus_b.SW = 2'd0;

        // Reset, release, free run in solid white.
        repeat (3) applyStimulus(2'd0, 1'b1);
        repeat (600) applyStimulus(2'd0, 1'b0);

        // Colour bars from the next frame.
        repeat (250) applyStimulus(2'd1, 1'b0);

        // Checkerboard, then switch to ramp while dut_a is on line 2.
        repeat (220) applyStimulus(2'd2, 1'b0);
        guard = 0;
        while (exp_a[4:2] != 3'd2 && guard < 400) begin
            applyStimulus(2'd2, 1'b0);
            guard++;
        end
        applyStimulus(2'd3, 1'b0);
        repeat (400) applyStimulus(2'd3, 1'b0);

        // One-cycle reset while dut_a is on line 3.
        guard = 0;
        while (exp_a[4:2] != 3'd3 && guard < 400) begin
            applyStimulus(2'd3, 1'b0);
            guard++;
        end
        applyStimulus(2'd3, 1'b1);
        repeat (400) applyStimulus(2'd1, 1'b0);

        // Random SW changes and occasional reset pulses.
        for (int i = 0; i < 2000; i++) begin
            sw_n  = ($urandom_range(0, 19) == 0) ? 2'($urandom_range(0, 3)) : sw_cur;
            rst_n = ($urandom_range(0, 299) == 0);
            applyStimulus(sw_n, rst_n);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
Parametrised VGA raster generator with a built-in test-pattern engine. It replaces the fixed 640x480 sync and colour logic in top. It derives a pixel clock-enable from CLK_I, runs the horizontal and vertical counters, produces HS and VS with configurable polarity, and drives RGB from one of four switch-selected patterns. Pixel coordinates and a frame strobe are exported for downstream pixel sources.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, horizontal sync width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width (lines)
V_BP, 33, vertical back porch (lines)
HS_POL, 0, HS asserted level (0 = active-low)
VS_POL, 0, VS asserted level
CLK_DIV, 4, CLK_I cycles per pixel; must be >=1
COLOR_BITS, 4, bits per colour channel
CHK_LOG2, 5, checkerboard cell size is 2^CHK_LOG2 pixels
RAMP_SHIFT, 3, ramp pattern right-shift applied to x

Ports:
CLK_I  in  1  system clock
reset  in  1  synchronous, active-high reset
SW  in  2  pattern mode select
VGA_HS_O  out  1  horizontal sync
VGA_VS_O  out  1  vertical sync
VGA_R  out  COLOR_BITS  red
VGA_G  out  COLOR_BITS  green
VGA_B  out  COLOR_BITS  blue
pix_x  out  clog2(H_TOTAL)  x coordinate of the pixel currently on the outputs
pix_y  out  clog2(V_TOTAL)  y coordinate of the pixel currently on the outputs
active  out  1  high while the output pixel is in the visible area
frame_start  out  1  one-CLK_I pulse when pixel (0,0) is presented

Behaviour:
- One clock (CLK_I). reset is synchronous and active-high; all state is updated on the CLK_I rising edge.
- Totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP and V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP.
- Divider: div_cnt counts 0..CLK_DIV-1 and wraps to 0. pix_ce is high when div_cnt == CLK_DIV-1. With CLK_DIV=1, pix_ce is high every cycle.
- Counters advance only when pix_ce is high:
  - h increments and wraps from H_TOTAL-1 to 0.
  - v increments on the h wrap and wraps from V_TOTAL-1 to 0.
- Output register: on each pix_ce, all outputs are loaded from the current (h,v), then the counters advance. Outputs hold between pix_ce pulses, so latency is 1 pixel tick from counter to pins.
  - The first pix_ce after reset presents (0,0).
- Sync regions:
  - HS is asserted for h in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1], otherwise deasserted.
  - VS is asserted for v in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1], otherwise deasserted.
  - Asserted level is HS_POL / VS_POL.
- active = (h < H_ACTIVE) && (v < V_ACTIVE). When active is low, RGB = 0.
- Mode latch: mode_q samples SW only on a pix_ce with (h,v) = (0,0). A mode change mid-frame takes effect at the next frame; no frame ever mixes patterns.
- Patterns (MAX = all COLOR_BITS ones):
  - 0, solid white: R = G = B = MAX.
  - 1, colour bars: BAR_W = H_ACTIVE/8 (integer). A bar counter b (3 bits) resets to 0 at h=0 and increments every BAR_W pixels, saturating at 7. R = b[2]?MAX:0, G = b[1]?MAX:0, B = b[0]?MAX:0.
  - 2, checkerboard: R = G = B = (h[CHK_LOG2] ^ v[CHK_LOG2]) ? MAX : 0.
  - 3, ramp: R = G = B = (h >> RAMP_SHIFT) truncated to COLOR_BITS; wraps modulo 2^COLOR_BITS.
- frame_start is high for exactly the single CLK_I cycle following the pix_ce that loads (0,0).
- Reset values: div_cnt = h = v = 0, mode_q = 0. Outputs: HS = !HS_POL, VS = !VS_POL, RGB = 0, pix_x = pix_y = 0, active = 0, frame_start = 0.
- Reset asserted mid-frame: restores all reset values on the next edge, regardless of pix_ce. After release, the frame restarts from (0,0) with mode_q = 0.
- Changing SW while reset is high has no effect until the first frame boundary after release.

Test Plan:
Small config used throughout: H 8/2/2/2, V 4/1/1/1, CLK_DIV=2 (H_TOTAL=14, V_TOTAL=7).
1. Reset, then release -> outputs at reset values until the first pix_ce (cycle 2). Then pix_x=0, pix_y=0, active=1, RGB=F (mode 0), frame_start=1 for one cycle.
2. Free run for 600 cycles -> frame_start period is exactly 196 CLK_I cycles. HS is low while pix_x = 10..11 (4 cycles per line). VS is low for the whole of line 5 (28 cycles).
3. SW=1 -> from the next frame, line 0 shows R,G,B = (0,0,0), (0,0,F), (0,F,0), ... (F,F,F) for x=0..7, and RGB=0 for x=8..13.
4. Change SW from 2 to 3 while pix_y=2 -> the current frame stays checkerboard (CHK_LOG2=1). The next frame shows the ramp (RAMP_SHIFT=0): R = x for x=0..7.
5. Assert reset for 1 cycle while pix_y=3 -> on the next edge, HS=1, VS=1, RGB=0, mode_q=0. After release, the next frame_start arrives exactly 2 cycles later.
6. Rebuild with CLK_DIV=1, HS_POL=1 -> pix_x advances every cycle, HS is high for x=10..11, and the frame period is 98 cycles.
